// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result producer, the result stage and writeback.
// Valid/ready: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface alu_result_stage_if #(
    parameter int N      = 8,
    parameter int DEST_W = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_result;
    logic [3:0]        in_flags_n_z_v_c;
    logic              in_set_flags;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_result;
    logic [DEST_W-1:0] out_dest;
    logic              clear_flags;
    logic [3:0]        status_n_z_v_c;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_result, in_flags_n_z_v_c, in_set_flags, in_dest,
        output out_ready, clear_flags,
        input  in_ready, out_valid, out_result, out_dest, status_n_z_v_c, occupancy
    );

    modport slave (
        input  in_valid, in_result, in_flags_n_z_v_c, in_set_flags, in_dest,
        input  out_ready, clear_flags,
        output in_ready, out_valid, out_result, out_dest, status_n_z_v_c, occupancy
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry in-order elastic buffer for ALU results; retiring flag-setting entries
// update the architectural NZVC status register.
module alu_result_stage #(
    parameter int N      = 8,
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_result_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    occ_state_t        r_state;
    logic              r_head;
    logic              r_tail;
    logic [N-1:0]      r_result [2];
    logic [3:0]        r_flags  [2];
    logic              r_set    [2];
    logic [DEST_W-1:0] r_dest   [2];
    logic [3:0]        r_status;

    logic w_accept;
    logic w_retire;

    // Ready comes only from the registered state, so out_ready never reaches in_ready.
    assign w_accept = bus.in_valid  && (r_state != FULL);
    assign w_retire = bus.out_ready && (r_state != EMPTY);

    assign bus.in_ready       = (r_state != FULL);
    assign bus.out_valid      = (r_state != EMPTY);
    assign bus.out_result     = r_result[r_head];
    assign bus.out_dest       = r_dest[r_head];
    assign bus.status_n_z_v_c = r_status;
    assign bus.occupancy      = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_status <= 4'b0000;
            for (int i = 0; i < 2; i++) begin
                r_result[i] <= '0;
                r_flags[i]  <= 4'b0000;
                r_set[i]    <= 1'b0;
                r_dest[i]   <= '0;
            end
        end else begin
            if (w_accept) begin
                r_result[r_tail] <= bus.in_result;
                r_flags[r_tail]  <= bus.in_flags_n_z_v_c;
                r_set[r_tail]    <= bus.in_set_flags;
                r_dest[r_tail]   <= bus.in_dest;
                r_tail           <= ~r_tail;
            end
            if (w_retire) begin
                r_head <= ~r_head;
            end

            // A flag-setting retire takes priority over a same-cycle clear.
            if (w_retire && r_set[r_head]) begin
                r_status <= r_flags[r_head];
            end else if (bus.clear_flags) begin
                r_status <= 4'b0000;
            end

            case (r_state)
                EMPTY: if (w_accept) r_state <= HALF;
                HALF: begin
                    if (w_accept && !w_retire) begin
                        r_state <= FULL;
                    end else if (w_retire && !w_accept) begin
                        r_state <= EMPTY;
                    end
                end
                FULL:    if (w_retire) r_state <= HALF;
                default: r_state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_alu_result_stage;
    localparam int N      = 8;
    localparam int DEST_W = 3;

    typedef struct packed {
        logic [N-1:0]      result;
        logic [3:0]        flags;
        logic              set;
        logic [DEST_W-1:0] dest;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    entry_t     exp_q[$];
    logic [3:0] exp_status;

    alu_result_stage_if #(.N(N), .DEST_W(DEST_W)) bus ();

    alu_result_stage #(.N(N), .DEST_W(DEST_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic [N-1:0] r, input logic [3:0] f,
                         input logic s, input logic [DEST_W-1:0] d,
                         input logic ordy, input logic clr);
        bus.in_valid         = v;
        bus.in_result        = r;
        bus.in_flags_n_z_v_c = f;
        bus.in_set_flags     = s;
        bus.in_dest          = d;
        bus.out_ready        = ordy;
        bus.clear_flags      = clr;
    endtask

    // Advance one clock and apply the reference queue/status rules to the inputs in force.
    task automatic tick();
        bit     acc;
        bit     ret;
        entry_t e;
        entry_t head;
        acc = bus.in_valid && (exp_q.size() < 2);
        ret = bus.out_ready && (exp_q.size() > 0);
        e.result = bus.in_result;
        e.flags  = bus.in_flags_n_z_v_c;
        e.set    = bus.in_set_flags;
        e.dest   = bus.in_dest;
        @(posedge clk);
        if (ret) begin
            head = exp_q.pop_front();
            if (head.set) exp_status = head.flags;
            else if (bus.clear_flags) exp_status = 4'b0000;
        end else if (bus.clear_flags) begin
            exp_status = 4'b0000;
        end
        if (acc) exp_q.push_back(e);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        exp_q.delete();
        exp_status = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_result !== 8'h00) begin n_errors++; $display("FAIL reset_out_result: got %h want 00", bus.out_result); end
        n_checks++; if (bus.out_dest !== 3'd0) begin n_errors++; $display("FAIL reset_out_dest: got %0d want 0", bus.out_dest); end
        n_checks++; if (bus.status_n_z_v_c !== 4'b0000) begin n_errors++; $display("FAIL reset_status: got %b want 0000", bus.status_n_z_v_c); end
        n_checks++; if (bus.occupancy !== 2'd0) begin n_errors++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive(1, 8'h0F, 4'b0100, 1, 3'd3, 1, 0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_result !== 8'h0F) begin n_errors++; $display("FAIL single_out_result: got %h want 0f", bus.out_result); end
        n_checks++; if (bus.out_dest !== 3'd3) begin n_errors++; $display("FAIL single_out_dest: got %0d want 3", bus.out_dest); end
        n_checks++; if (bus.occupancy !== 2'd1) begin n_errors++; $display("FAIL single_occ1: got %0d want 1", bus.occupancy); end
        n_checks++; if (bus.status_n_z_v_c !== 4'b0000) begin n_errors++; $display("FAIL single_status_before: got %b want 0000", bus.status_n_z_v_c); end
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0100) begin n_errors++; $display("FAIL single_status_after: got %b want 0100", bus.status_n_z_v_c); end
        n_checks++; if (bus.occupancy !== 2'd0) begin n_errors++; $display("FAIL single_occ0: got %0d want 0", bus.occupancy); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_out_valid_end: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1, 8'h01, 4'b0000, 0, 3'd1, 0, 0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready0: got %b want 1", bus.in_ready); end
        tick();
        drive(1, 8'h03, 4'b0000, 0, 3'd2, 0, 0);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready1: got %b want 1", bus.in_ready); end
        tick();
        drive(1, 8'h07, 4'b0000, 0, 3'd4, 0, 0);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.occupancy !== 2'd2) begin n_errors++; $display("FAIL bp_occ_full: got %0d want 2", bus.occupancy); end
        n_checks++; if (bus.out_result !== 8'h01) begin n_errors++; $display("FAIL bp_head_stable: got %h want 01", bus.out_result); end
        tick();
        drive(1, 8'h07, 4'b0000, 0, 3'd4, 1, 0);
        n_checks++; if (bus.out_result !== 8'h01) begin n_errors++; $display("FAIL bp_retire_first: got %h want 01", bus.out_result); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_ready_during_retire: got %b want 0", bus.in_ready); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_ready_after_retire: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_result !== 8'h03) begin n_errors++; $display("FAIL bp_retire_second: got %h want 03", bus.out_result); end
        n_checks++; if (bus.out_dest !== 3'd2) begin n_errors++; $display("FAIL bp_dest_second: got %0d want 2", bus.out_dest); end
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (bus.out_result !== 8'h07) begin n_errors++; $display("FAIL bp_third: got %h want 07", bus.out_result); end
        n_checks++; if (bus.occupancy !== 2'd1) begin n_errors++; $display("FAIL bp_occ_third: got %0d want 1", bus.occupancy); end
        tick();
        n_checks++; if (bus.occupancy !== 2'd0) begin n_errors++; $display("FAIL bp_occ_end: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h10 + 8'(i), 4'b0000, 0, 3'(i), 1, 0);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); end
            if (i > 0) begin
                n_checks++; if (bus.out_result !== 8'h10 + 8'(i - 1)) begin n_errors++; $display("FAIL stream_out[%0d]: got %h want %h", i, bus.out_result, 8'h10 + 8'(i - 1)); end
                n_checks++; if (bus.occupancy !== 2'd1) begin n_errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, bus.occupancy); end
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (bus.out_result !== 8'h17) begin n_errors++; $display("FAIL stream_last: got %h want 17", bus.out_result); end
        tick();
        n_checks++; if (bus.occupancy !== 2'd0) begin n_errors++; $display("FAIL stream_occ_end: got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_flag_gating();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 8'h00, 4'b0100, 1, 3'd0, 1, 0);
        tick();
        drive(1, 8'h80, 4'b1000, 0, 3'd1, 1, 0);
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0100) begin n_errors++; $display("FAIL gate_status_set: got %b want 0100", bus.status_n_z_v_c); end
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0100) begin n_errors++; $display("FAIL gate_status_kept: got %b want 0100", bus.status_n_z_v_c); end
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0100) begin n_errors++; $display("FAIL gate_status_hold: got %b want 0100", bus.status_n_z_v_c); end
    endtask

    task automatic test_clear_collision();
        drive(1, 8'h55, 4'b1001, 1, 3'd5, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b1001) begin n_errors++; $display("FAIL clr_setup: got %b want 1001", bus.status_n_z_v_c); end
        drive(1, 8'h66, 4'b0010, 1, 3'd6, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0010) begin n_errors++; $display("FAIL clr_retire_wins: got %b want 0010", bus.status_n_z_v_c); end
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        n_checks++; if (bus.status_n_z_v_c !== 4'b0000) begin n_errors++; $display("FAIL clr_alone: got %b want 0000", bus.status_n_z_v_c); end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midflight();
        drive(1, 8'h11, 4'b1100, 1, 3'd1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 8'hA1, 4'b0011, 1, 3'd2, 0, 0);
        tick();
        drive(1, 8'hA2, 4'b0101, 1, 3'd3, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.occupancy !== 2'd2) begin n_errors++; $display("FAIL mid_occ_full: got %0d want 2", bus.occupancy); end
        n_checks++; if (bus.status_n_z_v_c !== 4'b1100) begin n_errors++; $display("FAIL mid_status_pre: got %b want 1100", bus.status_n_z_v_c); end
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_status = 4'b0000;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.status_n_z_v_c !== 4'b0000) begin n_errors++; $display("FAIL mid_status: got %b want 0000", bus.status_n_z_v_c); end
        n_checks++; if (bus.occupancy !== 2'd0) begin n_errors++; $display("FAIL mid_occ: got %0d want 0", bus.occupancy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_ghost[%0d]: out_valid got %b want 0", i, bus.out_valid); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
            n_checks++; if (bus.out_valid !== (exp_q.size() > 0)) begin n_errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", i, bus.out_valid, exp_q.size() > 0); end
            n_checks++; if (bus.in_ready !== (exp_q.size() < 2)) begin n_errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_q.size() < 2); end
            n_checks++; if (bus.occupancy !== 2'(exp_q.size())) begin n_errors++; $display("FAIL rand_occ[%0d]: got %0d want %0d", i, bus.occupancy, exp_q.size()); end
            n_checks++; if (bus.status_n_z_v_c !== exp_status) begin n_errors++; $display("FAIL rand_status[%0d]: got %b want %b", i, bus.status_n_z_v_c, exp_status); end
            if (exp_q.size() > 0) begin
                n_checks++; if (bus.out_result !== exp_q[0].result) begin n_errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, bus.out_result, exp_q[0].result); end
                n_checks++; if (bus.out_dest !== exp_q[0].dest) begin n_errors++; $display("FAIL rand_dest[%0d]: got %0d want %0d", i, bus.out_dest, exp_q[0].dest); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flag_gating();
        test_clear_collision();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
